// File: rtl/env_follower_pkg.sv
// env_follower_pkg: shared gate-detector state encoding for the envelope follower.
package env_follower_pkg;
  typedef enum logic [1:0] {
    CLOSED = 2'd0,
    OPEN   = 2'd1,
    HOLD   = 2'd2
  } gate_state_t;
endpackage

// File: rtl/env_smoother.sv
// env_smoother: full-wave rectify plus one-pole attack/release step (combinational).
module env_smoother
  import env_follower_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ENV_WIDTH    = 16,
  parameter int CTRL_WIDTH   = 4
) (
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  input  logic        [ENV_WIDTH-1:0]    env,
  input  logic        [CTRL_WIDTH-1:0]   a,
  input  logic        [CTRL_WIDTH-1:0]   r,
  output logic        [ENV_WIDTH-1:0]    env_next
);
  logic [SAMPLE_WIDTH-1:0] neg, mag;
  logic [ENV_WIDTH-1:0]    rect, up, dn;
  // step is clamped to >=1 and never exceeds the gap, so env lands on rect without wrap
  always_comb begin
    neg      = '0 - $unsigned(sample);
    mag      = !sample[SAMPLE_WIDTH-1] ? $unsigned(sample) :
               neg[SAMPLE_WIDTH-1] ? {1'b0, {(SAMPLE_WIDTH-1){1'b1}}} : neg;
    rect     = ENV_WIDTH'({mag[SAMPLE_WIDTH-2:0], 1'b0});
    up       = (rect - env) >> a;
    dn       = (env - rect) >> r;
    env_next = rect > env ? env + (up == '0 ? ENV_WIDTH'(1) : up) :
               rect < env ? env - (dn == '0 ? ENV_WIDTH'(1) : dn) : env;
  end
endmodule

// File: rtl/env_follower.sv
// env_follower: envelope follower with hysteretic gate and hold time.
// Optional peak register enabled by defining ENV_FOLLOWER_PEAK_EN.
module env_follower
  import env_follower_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ENV_WIDTH    = 16,
  parameter int CTRL_WIDTH   = 4,
  parameter int HOLD_SHIFT   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sample_valid,
  input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
  input  logic        [CTRL_WIDTH-1:0]   a,
  input  logic        [CTRL_WIDTH-1:0]   r,
  input  logic        [CTRL_WIDTH-1:0]   thresh,
  input  logic        [CTRL_WIDTH-1:0]   hold,
  input  logic                           peak_clr,
  output logic        [ENV_WIDTH-1:0]    env_out,
  output logic                           env_valid,
  output logic                           gate_out,
  output logic        [ENV_WIDTH-1:0]    peak_out
);
  localparam int HW = CTRL_WIDTH + HOLD_SHIFT;
  gate_state_t          state_q, state_d;
  logic [ENV_WIDTH-1:0] env_q, env_d, env_next, peak_q, peak_d, th_open, th_close;
  logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
  logic                 valid_q;
  env_smoother #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .ENV_WIDTH   (ENV_WIDTH),
    .CTRL_WIDTH  (CTRL_WIDTH)
  ) u_smoother (
    .sample  (sample_in),
    .env     (env_q),
    .a       (a),
    .r       (r),
    .env_next(env_next)
  );
  // gate decisions use the freshly smoothed value, not the registered one
  always_comb begin
    th_open    = ENV_WIDTH'(thresh) << (ENV_WIDTH - CTRL_WIDTH);
    th_close   = th_open >> 1;
    env_d      = sample_valid ? env_next : env_q;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    if (sample_valid) begin
      if (thresh == '0) state_d = CLOSED;
      else
        case (state_q)
          CLOSED: if (env_next >= th_open) state_d = OPEN;
          OPEN:
            if (env_next < th_close) begin
              state_d    = HOLD;
              hold_cnt_d = HW'(hold) << HOLD_SHIFT;
            end
          HOLD:
            if (env_next >= th_open) state_d = OPEN;
            else if (hold_cnt_q == '0) state_d = CLOSED;
            else hold_cnt_d = hold_cnt_q - HW'(1);
          default: state_d = CLOSED;
        endcase
    end
`ifdef ENV_FOLLOWER_PEAK_EN
    peak_d = peak_clr ? (sample_valid ? env_next : '0) :
             (sample_valid && env_next > peak_q) ? env_next : peak_q;
`else
    peak_d = '0;
`endif
  end
`ifndef ENV_FOLLOWER_PEAK_EN
  logic unused_peak_clr;
  assign unused_peak_clr = peak_clr;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      env_q      <= '0;
      valid_q    <= 1'b0;
      state_q    <= CLOSED;
      hold_cnt_q <= '0;
      peak_q     <= '0;
    end else begin
      env_q      <= env_d;
      valid_q    <= sample_valid;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      peak_q     <= peak_d;
    end
  end
  assign env_out   = env_q;
  assign env_valid = valid_q;
  assign gate_out  = state_q != CLOSED;
  assign peak_out  = peak_q;
endmodule

// File: tb/tb_env_follower.sv
// tb_env_follower: directed self-checking bench for env_follower.
module tb_env_follower;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_valid = 1'b0;
  logic signed [15:0] sample_in = '0;
  logic [3:0]         a = '0, r = '0, thresh = '0, hold = '0;
  logic               peak_clr = 1'b0;
  logic [15:0]        env_out, peak_out;
  logic               env_valid, gate_out;
  int                 checks = 0, failures = 0;
  always #5 clk = ~clk;
  env_follower dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_in   (sample_in),
    .a           (a),
    .r           (r),
    .thresh      (thresh),
    .hold        (hold),
    .peak_clr    (peak_clr),
    .env_out     (env_out),
    .env_valid   (env_valid),
    .gate_out    (gate_out),
    .peak_out    (peak_out)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic send(input int s);
    @(negedge clk);
    sample_in    = 16'(s);
    sample_valid = 1'b1;
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask
  initial begin
    int prev, ones;
    bit mono, reached;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_env", env_out, 0);
    chk("rst_valid", env_valid, 0);
    chk("rst_gate", gate_out, 0);
    chk("rst_peak", peak_out, 0);
    @(negedge clk) rst = 1'b0;
    send(16384);
    chk("step_env", env_out, 32768);
    chk("step_valid", env_valid, 1);
    chk("step_gate_thresh0", gate_out, 0);
    @(posedge clk);
    #1 chk("step_valid_pulse", env_valid, 0);
    send(0);
    chk("release_instant", env_out, 0);
    a = 4'd2;
    send(16384);
    chk("attack_1", env_out, 8192);
    send(16384);
    chk("attack_2", env_out, 14336);
    send(16384);
    chk("attack_3", env_out, 18944);
    prev = env_out; mono = 1; reached = 0;
    for (int i = 0; i < 80 && !reached; i++) begin
      send(16384);
      if (env_out < prev || env_out > 32768) mono = 0;
      prev = env_out;
      if (env_out == 32768) reached = 1;
    end
    chk("attack_mono", mono, 1);
    chk("attack_reach", reached, 1);
    a = 4'd0;
    send(-32768);
    chk("sat_env", env_out, 65534);
    r = 4'd15;
    send(0);
    chk("rel15_1", env_out, 65533);
    send(0);
    chk("rel15_2", env_out, 65532);
    repeat (5) @(posedge clk);
    #1 chk("idle_hold", env_out, 65532);
    r = 4'd0;
    send(0);
    thresh = 4'd8; hold = 4'd1;
    send(20000);
    chk("gate_open_env", env_out, 40000);
    chk("gate_open", gate_out, 1);
    send(20000);
    chk("gate_stay", gate_out, 1);
    send(0);
    chk("gate_hold_entry", gate_out, 1);
    ones = 0;
    for (int i = 0; i < 256; i++) begin send(0); if (gate_out) ones++; end
    chk("hold_len", ones, 256);
    send(0);
    chk("hold_close", gate_out, 0);
    send(20000);
    send(0);
    for (int i = 0; i < 156; i++) send(0);
    chk("retrig_pre", gate_out, 1);
    send(20000);
    chk("retrig_open", gate_out, 1);
    send(0);
    ones = 0;
    for (int i = 0; i < 256; i++) begin send(0); if (gate_out) ones++; end
    chk("retrig_reload", ones, 256);
    send(0);
    chk("retrig_close", gate_out, 0);
    hold = 4'd0;
    send(20000);
    send(0);
    chk("hold0_entry", gate_out, 1);
    send(0);
    chk("hold0_close", gate_out, 0);
    send(20000);
    thresh = 4'd0;
    send(20000);
    chk("thresh0_force", gate_out, 0);
    send(20000);
    chk("thresh0_stay", gate_out, 0);
    @(negedge clk) peak_clr = 1'b1;
    @(posedge clk);
    #1 peak_clr = 1'b0;
    chk("peak_clr_first", peak_out, 0);
    send(15000);
    send(5000);
    chk("peak_env", env_out, 10000);
`ifdef ENV_FOLLOWER_PEAK_EN
    chk("peak_max", peak_out, 30000);
    @(negedge clk) peak_clr = 1'b1;
    @(posedge clk);
    #1 peak_clr = 1'b0;
    chk("peak_clr", peak_out, 0);
    peak_clr = 1'b1;
    send(6000);
    peak_clr = 1'b0;
    chk("peak_clr_sample", peak_out, 12000);
`else
    chk("peak_off", peak_out, 0);
`endif
    thresh = 4'd8; hold = 4'd1;
    send(20000);
    send(0);
    chk("pre_rst_gate", gate_out, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_env", env_out, 0);
    chk("arst_valid", env_valid, 0);
    chk("arst_gate", gate_out, 0);
    chk("arst_peak", peak_out, 0);
    @(negedge clk) rst = 1'b0;
    thresh = 4'd0;
    send(16384);
    chk("post_rst_env", env_out, 32768);
    chk("post_rst_valid", env_valid, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
